// File: rtl/logic_mux_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_mux_pipe : one-hot NCH-way channel mux with a valid/ready output   |
// | register and a saturating illegal-select counter.                        |
// | Option macro LOGIC_MUX_HOLD_EN: illegal selects replay the last legal    |
// | result instead of zero.                                                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module logic_mux_pipe #(
  parameter int WIDTH     = 4,
  parameter int NCH       = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH-1:0]         mux_selector,
  input  logic [NCH*WIDTH-1:0]   mux_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       mux_out,
  output logic                   out_err,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = {ERR_CNT_W{1'b1}};

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_mux_out;
  logic                 r_out_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_accept;
  logic                 w_any;
  logic                 w_multi;
  logic                 w_legal;
  logic [WIDTH-1:0]     w_sel_data;
  logic [WIDTH-1:0]     w_ill_data;
  logic [WIDTH-1:0]     w_next_data;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // x & (x-1) clears the lowest set bit, so a nonzero remainder means >1 bit.
  assign w_any   = |mux_selector;
  assign w_multi = |(mux_selector & (mux_selector - NCH'(1)));
  assign w_legal = w_any && !w_multi;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mux_selector[i]) begin
        w_sel_data = w_sel_data | mux_in[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef LOGIC_MUX_HOLD_EN
  logic [WIDTH-1:0] r_hold;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_hold <= '0;
    end else if (w_accept && w_legal) begin
      r_hold <= w_sel_data;
    end
  end

  assign w_ill_data = r_hold;
`else
  assign w_ill_data = '0;
`endif

  assign w_next_data = w_legal ? w_sel_data : w_ill_data;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_out_valid <= 1'b0;
      r_mux_out   <= '0;
      r_out_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_mux_out   <= w_next_data;
        r_out_err   <= !w_legal;
        if (!w_legal && (r_err_count != c_ERR_MAX)) begin
          r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign mux_out   = r_mux_out;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_logic_mux_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_logic_mux_pipe : directed self-checking bench for logic_mux_pipe.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_logic_mux_pipe;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // main instance: default parameters
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]  sel, mux_out;
  logic [15:0] mux_in;
  logic [7:0]  err_count;

  // saturation instance: ERR_CNT_W = 2
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
  logic [3:0]  s_sel, s_mux_out;
  logic [15:0] s_mux_in;
  logic [1:0]  s_err_count;

  // scale instance: NCH = 8, WIDTH = 16
  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_err;
  logic [7:0]   w_sel, w_err_count;
  logic [127:0] w_mux_in;
  logic [15:0]  w_mux_out;

  logic [3:0] exp_ill;

  logic_mux_pipe u_dut (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_ready(in_ready),
    .mux_selector(sel), .mux_in(mux_in), .out_valid(out_valid),
    .out_ready(out_ready), .mux_out(mux_out), .out_err(out_err),
    .err_count(err_count)
  );

  logic_mux_pipe #(.WIDTH(4), .NCH(4), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .reset_L(reset_L), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .mux_selector(s_sel), .mux_in(s_mux_in), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .mux_out(s_mux_out), .out_err(s_out_err),
    .err_count(s_err_count)
  );

  logic_mux_pipe #(.WIDTH(16), .NCH(8), .ERR_CNT_W(8)) u_wide (
    .clk(clk), .reset_L(reset_L), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .mux_selector(w_sel), .mux_in(w_mux_in), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .mux_out(w_mux_out), .out_err(w_out_err),
    .err_count(w_err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef LOGIC_MUX_HOLD_EN
    exp_ill = 4'hC;
`else
    exp_ill = 4'h0;
`endif
    in_valid = 0; sel = 0; mux_in = 16'hC5A3; out_ready = 1;
    s_in_valid = 0; s_sel = 0; s_mux_in = 16'h1234; s_out_ready = 1;
    w_in_valid = 0; w_sel = 0; w_out_ready = 1;
    for (int i = 0; i < 8; i++) w_mux_in[i*16 +: 16] = 16'h1000 + 16'(i);
    w_mux_in[7*16 +: 16] = 16'hBEEF;

    tick(); tick();
    reset_L = 1;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_mux",   32'(mux_out), 0);
    check("rst_err",   32'(out_err), 0);
    check("rst_cnt",   32'(err_count), 0);
    check("rst_ready", 32'(in_ready), 1);

    // sweep: channels {3,A,5,C} back to back
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp_tab;
      exp_tab = 16'hC5A3;
      sel = 4'(1 << i);
      tick();
      check($sformatf("sweep_mux%0d", i), 32'(mux_out), 32'(exp_tab[i*4 +: 4]));
      check($sformatf("sweep_err%0d", i), 32'(out_err), 0);
      check($sformatf("sweep_vld%0d", i), 32'(out_valid), 1);
    end
    in_valid = 0;
    tick();
    check("drain_vld", 32'(out_valid), 0);
    check("drain_mux", 32'(mux_out), 4'hC);

    // backpressure
    in_valid = 1; sel = 4'b0010; out_ready = 0;
    tick();
    check("bp_first", 32'(mux_out), 4'hA);
    sel = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), 32'(mux_out), 4'hA);
      check($sformatf("bp_rdy%0d", i), 32'(in_ready), 0);
      check($sformatf("bp_vld%0d", i), 32'(out_valid), 1);
    end
    out_ready = 1;
    #1;
    check("bp_rdy_rel", 32'(in_ready), 1);
    tick();
    check("bp_next", 32'(mux_out), 4'h5);
    check("bp_next_vld", 32'(out_valid), 1);

    // illegal selects after legal C
    sel = 4'b1000;
    tick();
    check("pre_ill", 32'(mux_out), 4'hC);
    sel = 4'b0000;
    tick();
    check("ill0_err", 32'(out_err), 1);
    check("ill0_mux", 32'(mux_out), 32'(exp_ill));
    check("ill0_cnt", 32'(err_count), 1);
    sel = 4'b0110;
    tick();
    check("ill1_err", 32'(out_err), 1);
    check("ill1_mux", 32'(mux_out), 32'(exp_ill));
    check("ill1_cnt", 32'(err_count), 2);
    sel = 4'b0001;
    tick();
    check("post_ill_mux", 32'(mux_out), 4'h3);
    check("post_ill_err", 32'(out_err), 0);
    check("post_ill_cnt", 32'(err_count), 2);

    // reset during a stall
    sel = 4'b0010; out_ready = 0;
    tick();
    check("stall_vld", 32'(out_valid), 1);
    in_valid = 0;
    reset_L = 0;
    #1;
    check("mrst_vld", 32'(out_valid), 0);
    check("mrst_mux", 32'(mux_out), 0);
    check("mrst_cnt", 32'(err_count), 0);
    check("mrst_err", 32'(out_err), 0);
    tick();
    reset_L = 1;
    #1;
    check("mrst_rdy", 32'(in_ready), 1);

    // saturation with a 2-bit counter
    s_in_valid = 1; s_sel = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      if (i == 1) s_sel = 4'b1111;
      tick();
      check($sformatf("sat%0d", i), 32'(s_err_count), 32'(exp_cnt));
      check($sformatf("sat_err%0d", i), 32'(s_out_err), 1);
    end
    s_in_valid = 0;

    // 8 channels of 16 bits
    w_in_valid = 1; w_sel = 8'h80;
    tick();
    check("wide_ch7", 32'(w_mux_out), 16'hBEEF);
    check("wide_err", 32'(w_out_err), 0);
    w_sel = 8'h08;
    tick();
    check("wide_ch3", 32'(w_mux_out), 16'h1003);
    w_sel = 8'h81;
    tick();
    check("wide_ill_err", 32'(w_out_err), 1);
    check("wide_ill_cnt", 32'(w_err_count), 1);
    w_in_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
